ms_wr_sequencer: RTL and testbench
==================================

# ms_wr_sequencer

Upstream stage of the master/slave register bus. Accepts register-write commands (address + data) from a producer over a valid/ready handshake, buffers them in a small FIFO, and issues them on the pipelined master side of the bus. The address phase leads the data phase by one cycle, and both phases hold while the slave deasserts `sready`. Its bus outputs drive the slave's `addr`/`data` inputs directly.

## Interface
- `AW`, 2: address width.
- `DW`, 8: data width.
- `DEPTH`, 4: command FIFO depth; power of two, ≥2.

- `clk` in 1: the single clock.
- `rstn` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: producer has a command.
- `req_ready` out 1: FIFO can accept; `= !full`.
- `req_addr` in AW: command register address.
- `req_data` in DW: command write data.
- `sready` in 1: slave ready, sampled at `posedge clk`.
- `addr` out AW: bus address phase, registered.
- `data` out DW: bus data phase, registered.
- `count` out $clog2(DEPTH)+1: FIFO occupancy.
- `issued` out 8: commands moved into address phase; wraps 255→0.
- `idle` out 1: FIFO empty and data phase matches address-stage data.

## Operation
- **Push:** the FIFO is written when `req_valid && req_ready` at the edge. There is no bypass, so a full FIFO never accepts.
- **Advance:** `adv = sready`. On `adv`:
  - `data <= astage_d`, the data belonging to the current address phase.
  - If the FIFO is non-empty, pop one command into the address stage: `addr <= cmd.addr`, `astage_d <= cmd.data`, `issued++`.
  - If the FIFO is empty, `addr` and `astage_d` hold. The slave re-writes the last command's value, which is idempotent.
- **Stall:** when `sready=0`, `addr`, `data`, `astage_d`, `issued` and the FIFO read pointer all hold. Pushes still proceed.
- **Simultaneous push and pop:** `count` is unchanged, and both pointers advance modulo DEPTH.
- **Reset mid-operation:** the FIFO is flushed and no command is completed.
- **Reset values:** `addr=0`, `data=0`, `astage_d=0`, `count=0`, `issued=0`, `req_ready=1`, `idle=1`. The resulting bus writes 0 to register 0, matching the slave's reset value.
- **Widths and wrap:** pointers are `$clog2(DEPTH)` bits wide and wrap. `count` saturates at neither end, and the handshake prevents overflow and underflow.

## Timing
- **Command accept:** a command is accepted at edge E0. With the FIFO previously empty and `sready=1`, `addr` shows it after E1 and `data` after E2. The slave commits it at E3.
- **Throughput:** back-to-back commands with `sready=1` are issued one per cycle, with address and data phases overlapped (pipelined).
- **Stall latency:** each cycle of `sready=0` adds exactly one cycle to every in-flight phase.
- **`req_ready`:** combinational from `count` only. It is not dependent on `sready` in the same cycle.
- **`idle`:** registered-equivalent, derived from registers only.

## Structure
- **Package `ms_pkg`:**
  - `localparam AW=2`, `DW=8`.
  - `typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data;} ms_cmd_t`.
- **Sub-module `ms_cmd_fifo`:** parameterised by DEPTH and `ms_cmd_t`. It owns the push/pop, pointers and `count`.
- **Top level:** holds the address stage and data stage plus the `issued` counter. It is instantiated beside the master/slave pair in the design top, and the `addr`/`data`/`sready` ports connect to the bus interface.

## Test plan
- **Reset:** hold `rstn=0` for 5 cycles.
  - Required during reset: `addr=0`, `data=0`, `count=0`, `req_ready=1`, `idle=1`.
  - Release and send no commands: the outputs stay constant.
- **Single write:** push (2, 0x5A) with `sready=1`. Required: `addr=2` one edge after push, `data=0x5A` the next edge, `issued=1`, `idle=1` afterwards.
- **Burst:** push (0,0x11), (1,0x22), (2,0x33), (3,0x44) on consecutive cycles with `sready=1`. Required: `addr` sequence 0,1,2,3 and `data` sequence 0x11..0x44, each one cycle behind its address; `count` never exceeds 1.
- **Full / backpressure:** hold `sready=0` and push 5 commands. Required:
  - `count` reaches 4 and `req_ready=0`.
  - The 5th command is not accepted until `sready=1` frees a slot.
  - Order is preserved.
- **Stall mid-burst:** drop `sready` for 3 cycles while address 1 / data 0x11 are presented. Required: both hold for exactly 3 cycles, then resume with no loss or duplication, and `issued` is correct.
- **Reset mid-operation:** assert `rstn` asynchronously with 3 commands queued. Required:
  - Outputs reach their reset values without waiting for an edge.
  - After release, the flushed commands never appear on the bus.

Source files
------------

// File: rtl/ms_wr_sequencer_pkg.sv
// ms_pkg: shared widths and the command record for the register-write
// sequencer.
//   AW       - register address width
//   DW       - register data width
//   ms_cmd_t - one queued write command {addr, data}
package ms_pkg;

  localparam int AW = 2;
  localparam int DW = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ms_cmd_t;

endpackage

// File: rtl/ms_wr_sequencer_if.sv
// ms_wr_sequencer_if: producer handshake plus master-side bus signals of the
// register-write sequencer.
//   req_valid/req_ready/req_addr/req_data - producer command handshake
//   sready                                - slave ready (advances the pipe)
//   addr/data                             - bus address and data phases
//   count/issued/idle                     - status
// modport master: the sequencer; modport slave: the environment around it.
interface ms_wr_sequencer_if
  import ms_pkg::*;
#(
  parameter int DEPTH = 4
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          sready;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [CW-1:0] count;
  logic [7:0]    issued;
  logic          idle;

  modport master (
    input  req_valid, req_addr, req_data, sready,
    output req_ready, addr, data, count, issued, idle
  );

  modport slave (
    output req_valid, req_addr, req_data, sready,
    input  req_ready, addr, data, count, issued, idle
  );

endinterface

// File: rtl/ms_wr_sequencer_cmd_fifo.sv
// ms_cmd_fifo: command FIFO feeding the sequencer's address stage.
//   clk, rstn            - clock, async active-low reset (flushes pointers)
//   push_i, push_data_i  - write request; ignored while full
//   pop_i, pop_data_o    - read request; ignored while empty; data is head
//   empty_o, full_o      - occupancy flags, decoded from count_o only
//   count_o              - occupancy, 0..DEPTH
module ms_cmd_fifo
  import ms_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = ms_cmd_t
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push_i,
  input  T                           push_data_i,
  input  logic                       pop_i,
  output T                           pop_data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read until the pointers say so.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ms_wr_sequencer.sv
// ms_wr_sequencer: buffers register-write commands and issues them on the
// pipelined master bus, address phase one cycle ahead of data phase.
//   clk  - clock
//   rstn - async active-low reset; flushes queued commands
//   bus  - master modport: producer handshake, sready, addr/data phases,
//          count/issued/idle status
module ms_wr_sequencer
  import ms_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                clk,
  input logic                rstn,
  ms_wr_sequencer_if.master  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  ms_cmd_t       push_cmd, head_cmd;
  logic          fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;
  logic          adv, pop;

  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] astage_q, astage_d;
  logic [DW-1:0] data_q, data_d;
  logic [7:0]    issued_q, issued_d;

  assign push_cmd = '{addr: bus.req_addr, data: bus.req_data};
  assign adv      = bus.sready;
  assign pop      = adv && !fifo_empty;

  ms_cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (ms_cmd_t)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (bus.req_valid),
    .push_data_i (push_cmd),
    .pop_i       (pop),
    .pop_data_o  (head_cmd),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  // With an empty FIFO the address stage holds, so the slave simply rewrites
  // the last command, which is harmless.
  always_comb begin
    addr_d   = addr_q;
    astage_d = astage_q;
    data_d   = data_q;
    issued_d = issued_q;
    if (adv) begin
      data_d = astage_q;
      if (pop) begin
        addr_d   = head_cmd.addr;
        astage_d = head_cmd.data;
        issued_d = issued_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q   <= '0;
      astage_q <= '0;
      data_q   <= '0;
      issued_q <= '0;
    end else begin
      addr_q   <= addr_d;
      astage_q <= astage_d;
      data_q   <= data_d;
      issued_q <= issued_d;
    end
  end

  assign bus.req_ready = !fifo_full;
  assign bus.addr      = addr_q;
  assign bus.data      = data_q;
  assign bus.count     = fifo_count;
  assign bus.issued    = issued_q;
  assign bus.idle      = fifo_empty && (data_q == astage_q);

endmodule

// File: tb/tb_ms_wr_sequencer.sv
module tb_ms_wr_sequencer;
  import ms_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  ms_wr_sequencer_if #(.DEPTH(DEPTH)) bus ();

  ms_wr_sequencer #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a command queue plus the three bus-visible stages.
  ms_cmd_t       mq[$];
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_astage;
  logic [DW-1:0] m_data;
  int            m_issued;

  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          s;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    int            ec;
    logic          er;
    logic          ei;
    int            eiss;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_addr   = '0;
    m_astage = '0;
    m_data   = '0;
    m_issued = 0;
  endtask

  task automatic model_edge();
    bit      acc, pp;
    ms_cmd_t c;
    acc = bus.req_valid && (mq.size() < DEPTH);
    pp  = bus.sready && (mq.size() > 0);
    if (bus.sready) m_data = m_astage;
    if (pp) begin
      c        = mq.pop_front();
      m_addr   = c.addr;
      m_astage = c.data;
      m_issued = (m_issued + 1) % 256;
    end
    if (acc) begin
      c.addr = bus.req_addr;
      c.data = bus.req_data;
      mq.push_back(c);
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, " addr"},   int'(bus.addr),      int'(m_addr));
    chk({tag, " data"},   int'(bus.data),      int'(m_data));
    chk({tag, " count"},  int'(bus.count),     mq.size());
    chk({tag, " ready"},  int'(bus.req_ready), int'(mq.size() < DEPTH));
    chk({tag, " idle"},   int'(bus.idle),      int'(mq.size() == 0 && m_data == m_astage));
    chk({tag, " issued"}, int'(bus.issued),    m_issued);
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic s);
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.sready    = s;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " addr"},   int'(bus.addr),      0);
    chk({tag, " data"},   int'(bus.data),      0);
    chk({tag, " count"},  int'(bus.count),     0);
    chk({tag, " ready"},  int'(bus.req_ready), 1);
    chk({tag, " idle"},   int'(bus.idle),      1);
    chk({tag, " issued"}, int'(bus.issued),    0);
  endtask

  initial begin
    logic [DW-1:0] seen[$];
    logic [DW-1:0] prev;

    //        v     a     d      s     ea    ed     ec ready idle iss
    tbl[0] = '{1'b1, 2'd2, 8'h5A, 1'b1, 2'd0, 8'h00, 1, 1'b1, 1'b0, 0};
    tbl[1] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'h00, 0, 1'b1, 1'b0, 1};
    tbl[2] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'h5A, 0, 1'b1, 1'b1, 1};
    tbl[3] = '{1'b1, 2'd0, 8'h11, 1'b1, 2'd2, 8'h5A, 1, 1'b1, 1'b0, 1};
    tbl[4] = '{1'b1, 2'd1, 8'h22, 1'b1, 2'd0, 8'h5A, 1, 1'b1, 1'b0, 2};
    tbl[5] = '{1'b1, 2'd2, 8'h33, 1'b1, 2'd1, 8'h11, 1, 1'b1, 1'b0, 3};
    tbl[6] = '{1'b1, 2'd3, 8'h44, 1'b1, 2'd2, 8'h22, 1, 1'b1, 1'b0, 4};
    tbl[7] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 8'h33, 0, 1'b1, 1'b0, 5};
    tbl[8] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 8'h44, 0, 1'b1, 1'b1, 5};
    tbl[9] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 8'h44, 0, 1'b1, 1'b1, 5};

    rstn = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    model_reset();

    // Reset held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk_reset_vals("in reset");
    end
    rstn = 1'b1;

    // No commands: outputs stay at reset values
    for (int i = 0; i < 3; i++) begin
      cycle("quiet");
      chk_reset_vals("quiet const");
    end

    // Single write then burst, cycle by cycle
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].s);
      cycle("vec model");
      chk($sformatf("vec%0d addr", i),   int'(bus.addr),      int'(tbl[i].ea));
      chk($sformatf("vec%0d data", i),   int'(bus.data),      int'(tbl[i].ed));
      chk($sformatf("vec%0d count", i),  int'(bus.count),     tbl[i].ec);
      chk($sformatf("vec%0d ready", i),  int'(bus.req_ready), int'(tbl[i].er));
      chk($sformatf("vec%0d idle", i),   int'(bus.idle),      int'(tbl[i].ei));
      chk($sformatf("vec%0d issued", i), int'(bus.issued),    tbl[i].eiss);
    end

    // Full / backpressure: fill under sready=0, 5th command must wait
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, AW'(i), 8'hA0 + 8'(i), 1'b0);
      cycle("fill");
    end
    chk("full count", int'(bus.count), 4);
    chk("full ready", int'(bus.req_ready), 0);
    drive(1'b1, 2'd0, 8'hA4, 1'b0);
    cycle("fifth blocked");
    chk("fifth blocked count", int'(bus.count), 4);
    prev = bus.data;
    for (int i = 0; i < 8; i++) begin
      drive(i < 2, 2'd0, 8'hA4, 1'b1);
      cycle("drain");
      if (i == 0) chk("drain pop only count", int'(bus.count), 3);
      if (i == 1) chk("drain push+pop count", int'(bus.count), 3);
      if (bus.data != prev) seen.push_back(bus.data);
      prev = bus.data;
    end
    chk("order n", seen.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < seen.size()) chk($sformatf("order %0d", i), int'(seen[i]), 'hA0 + i);
    chk("full issued", int'(bus.issued), 10);

    // Stall mid-burst with addr 1 / data 0x11 presented
    drive(1'b1, 2'd0, 8'h11, 1'b1); cycle("stall setup");
    drive(1'b1, 2'd1, 8'h22, 1'b1); cycle("stall setup");
    drive(1'b1, 2'd2, 8'h33, 1'b1); cycle("stall setup");
    chk("pre-stall addr", int'(bus.addr), 1);
    chk("pre-stall data", int'(bus.data), 'h11);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, 1'b0);
      cycle("stall");
      chk($sformatf("stall%0d addr", i), int'(bus.addr), 1);
      chk($sformatf("stall%0d data", i), int'(bus.data), 'h11);
    end
    drive(1'b0, '0, '0, 1'b1);
    cycle("resume");
    chk("resume1 addr", int'(bus.addr), 2);
    chk("resume1 data", int'(bus.data), 'h22);
    cycle("resume");
    chk("resume2 addr", int'(bus.addr), 2);
    chk("resume2 data", int'(bus.data), 'h33);
    chk("stall issued", int'(bus.issued), 13);

    // Asynchronous reset with 3 commands queued
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd3, 8'hC1 + 8'(i), 1'b0);
      cycle("queue");
    end
    chk("queued count", int'(bus.count), 3);
    drive(1'b0, '0, '0, 1'b1);
    #3;
    rstn = 1'b0;
    #1;
    chk_reset_vals("async reset");
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle("post reset");
      chk("flushed data", int'(bus.data inside {8'hC1, 8'hC2, 8'hC3}), 0);
      chk("flushed count", int'(bus.count), 0);
    end

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, AW'($urandom), DW'($urandom),
            (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0));
      cycle("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
